timer_alarm_scheduler: RTL and testbench

- MMIO slot core that shares one free-running 48-bit timer count among NUM_CH independent alarm channels.
- Each channel compares the count against a programmable 48-bit target, either once or periodically, and sets a pending flag.
- Pending flags are masked into a single registered irq line.
- Sits beside the timer core in the MMIO subsystem; takes the timer's count as an input and drives the interrupt controller.

---
 rtl/timer_alarm_scheduler_pkg.sv | 16 +
 rtl/timer_alarm_scheduler_alarm_channel.sv | 58 +++++
 rtl/timer_alarm_scheduler.sv | 94 +++++++++
 tb/tb_timer_alarm_scheduler.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/timer_alarm_scheduler_pkg.sv
// timer_pkg: shared count width, register offsets, ctrl bit positions and channel state type
package timer_pkg;
  localparam int CNT_W = 48;
  localparam logic [4:0] TGT_LO = 5'd0;
  localparam logic [4:0] TGT_HI = 5'd1;
  localparam logic [4:0] PERIOD = 5'd2;
  localparam logic [4:0] CTRL = 5'd3;
  localparam logic [4:0] PEND = 5'd16;
  localparam logic [4:0] MASK = 5'd17;
  localparam logic [4:0] CNT_LO = 5'd18;
  localparam logic [4:0] CNT_HI = 5'd19;
  localparam int CTRL_ARM = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_DISARM = 2;
  typedef enum logic {IDLE, ARMED} ch_state_t;
endpackage

// File: rtl/timer_alarm_scheduler_alarm_channel.sv
// alarm_channel: one alarm slot comparing the shared count against a target, one-shot or periodic
// Ports: clk, reset (async, active-high); count (shared timer count);
//   wr_tlo/wr_thi/wr_per/wr_ctrl (decoded register write strobes), wdata (write data),
//   w1c (clear pending); target, period, armed, periodic, pending, overrun (state for readback).
module alarm_channel import timer_pkg::*; #(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] count,
  input  logic         wr_tlo,
  input  logic         wr_thi,
  input  logic         wr_per,
  input  logic         wr_ctrl,
  input  logic [31:0]  wdata,
  input  logic         w1c,
  output logic [W-1:0] target,
  output logic [31:0]  period,
  output logic         armed,
  output logic         periodic,
  output logic         pending,
  output logic [7:0]   overrun
);
  ch_state_t state;
  logic [W-1:0] diff;
  logic hit, hit_q, reload;
  assign diff = count - target;
  assign armed = state == ARMED;
  // hit_q blocks re-evaluation for one cycle so the periodic target update lands before the next compare
  assign hit = armed && !diff[W-1] && !hit_q;
  assign reload = hit_q && armed && periodic && period != 32'd0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      target <= '0;
      period <= '0;
      periodic <= 1'b0;
      hit_q <= 1'b0;
      pending <= 1'b0;
      overrun <= '0;
    end else begin
      hit_q <= hit;
      if (!wr_tlo && !wr_thi && reload) target <= target + W'(period);
      if (wr_tlo) target[31:0] <= wdata;
      if (wr_thi) target[W-1:32] <= wdata[W-33:0];
      if (wr_per) period <= wdata;
      if (wr_ctrl && wdata[CTRL_DISARM]) state <= IDLE;
      else if (wr_ctrl && wdata[CTRL_ARM]) begin
        state <= ARMED;
        periodic <= wdata[CTRL_PERIODIC];
      end else if (hit_q && !reload) state <= IDLE;
      pending <= hit_q || (pending && !w1c);
      // a set racing a clear leaves overrun alone
      if (hit_q && pending && !w1c && overrun != 8'hFF) overrun <= overrun + 8'd1;
      else if (w1c && !hit_q) overrun <= '0;
    end
  end
endmodule

// File: rtl/timer_alarm_scheduler.sv
// timer_alarm_scheduler: MMIO slot sharing one timer count among NUM_CH alarm channels with masked irq
// Ports: clk, reset (async, active-high); cs/read/write/addr/wr_data (slot bus), rd_data (combinational
//   read data); count (free-running timer count); irq (registered level interrupt).
module timer_alarm_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = timer_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             read,
  input  logic             write,
  input  logic [4:0]       addr,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  input  logic [CNT_W-1:0] count,
  output logic             irq
);
  import timer_pkg::*;
  logic we;
  logic [1:0] c;
  logic [4:0] off;
  logic [CNT_W-1:0] tgt [4];
  logic [31:0] per [4];
  logic arm_a [4];
  logic perd_a [4];
  logic pend_a [4];
  logic [7:0] ovr [4];
  logic [3:0] pend_vec;
  logic [NUM_CH-1:0] mask;
  logic [CNT_W-33:0] snap_hi;
  assign we = cs && write;
  assign c = addr[3:2];
  assign off = {3'b0, addr[1:0]};
  for (genvar i = 0; i < 4; i++) begin : g_ch
    if (i < NUM_CH) begin : g_on
      logic sel;
      assign sel = we && !addr[4] && c == 2'(i);
      alarm_channel #(.W(CNT_W)) u_ch (
        .clk(clk),
        .reset(reset),
        .count(count),
        .wr_tlo(sel && off == TGT_LO),
        .wr_thi(sel && off == TGT_HI),
        .wr_per(sel && off == PERIOD),
        .wr_ctrl(sel && off == CTRL),
        .wdata(wr_data),
        .w1c(we && addr == PEND && wr_data[i]),
        .target(tgt[i]),
        .period(per[i]),
        .armed(arm_a[i]),
        .periodic(perd_a[i]),
        .pending(pend_a[i]),
        .overrun(ovr[i])
      );
    end else begin : g_off
      assign tgt[i] = '0;
      assign per[i] = '0;
      assign arm_a[i] = 1'b0;
      assign perd_a[i] = 1'b0;
      assign pend_a[i] = 1'b0;
      assign ovr[i] = '0;
    end
  end
  always_comb begin
    pend_vec = '0;
    for (int i = 0; i < 4; i++) pend_vec[i] = pend_a[i];
  end
  always_comb begin
    rd_data = '0;
    if (!addr[4])
      rd_data = off == TGT_LO ? tgt[c][31:0] :
                off == TGT_HI ? 32'(tgt[c][CNT_W-1:32]) :
                off == PERIOD ? per[c] :
                {16'h0, ovr[c], 5'h0, pend_a[c], perd_a[c], arm_a[c]};
    else
      rd_data = addr == PEND   ? 32'(pend_vec[NUM_CH-1:0]) :
                addr == MASK   ? 32'(mask) :
                addr == CNT_LO ? count[31:0] :
                addr == CNT_HI ? 32'(snap_hi) : 32'h0;
  end
  // reading the low count word freezes the high word so software gets a coherent 48-bit pair
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= '0;
      snap_hi <= '0;
      irq <= 1'b0;
    end else begin
      if (we && addr == MASK) mask <= wr_data[NUM_CH-1:0];
      if (cs && read && addr == CNT_LO) snap_hi <= count[CNT_W-1:32];
      irq <= |(pend_vec[NUM_CH-1:0] & mask);
    end
  end
endmodule

// File: tb/tb_timer_alarm_scheduler.sv
// tb_timer_alarm_scheduler: directed scoreboard bench for timer_alarm_scheduler
module tb_timer_alarm_scheduler;
  logic clk = 0, rst = 0, cs = 0, read = 0, write = 0, probe = 0;
  logic [4:0] addr = 0;
  logic [31:0] wr_data = 0, rd_data;
  logic [47:0] count = 0;
  logic irq;
  int n_chk = 0, n_fail = 0;
  typedef struct {string n; logic [31:0] v;} exp_t;
  exp_t rq[$], iq[$];
  always #5 clk = ~clk;
  timer_alarm_scheduler #(.NUM_CH(4), .CNT_W(48)) dut (
    .clk(clk), .reset(rst), .cs(cs), .read(read), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .count(count), .irq(irq)
  );
  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (cs && read) begin
      if (rq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_read: got 0x%08h, expected no read", rd_data);
      end else begin
        e = rq.pop_front();
        check(e.n, rd_data, e.v);
      end
    end
    if (probe) begin
      if (iq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_probe: got %0b, expected no probe", irq);
      end else begin
        e = iq.pop_front();
        check(e.n, {31'b0, irq}, e.v);
      end
    end
  end
  task automatic op(bit r, bit w, logic [4:0] a, logic [31:0] d, bit p);
    @(posedge clk); #1;
    cs = r | w; read = r; write = w; addr = a; wr_data = d; probe = p;
  endtask
  task automatic idle(int n = 1);
    repeat (n) op(0, 0, 0, 0, 0);
  endtask
  task automatic idle_c(logic [47:0] v);
    op(0, 0, 0, 0, 0);
    count = v;
  endtask
  task automatic wr(logic [4:0] a, logic [31:0] d);
    op(0, 1, a, d, 0);
  endtask
  task automatic rd(logic [4:0] a, logic [31:0] v, string n);
    exp_t e;
    e.n = n; e.v = v;
    rq.push_back(e);
    op(1, 0, a, 0, 0);
  endtask
  task automatic ir(logic v, string n);
    exp_t e;
    e.n = n; e.v = {31'b0, v};
    iq.push_back(e);
    op(0, 0, 0, 0, 1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end
  initial begin
    #2 rst = 1;
    idle(2);
    rst = 0;
    rd(3, 0, "rst_ch0_status");
    rd(16, 0, "rst_pending");
    rd(17, 0, "rst_mask");
    rd(0, 0, "rst_tlo");
    ir(0, "rst_irq");
    // one-shot on ch0
    wr(17, 1);
    wr(0, 32'h64);
    wr(1, 0);
    wr(3, 1);
    rd(0, 32'h64, "os_tlo");
    rd(3, 32'h1, "os_armed");
    idle_c(48'h63);
    rd(3, 32'h1, "os_before");
    idle_c(48'h64);
    rd(3, 32'h1, "os_hitq_cycle");
    rd(3, 32'h4, "os_pending");
    ir(1, "os_irq");
    wr(16, 1);
    rd(16, 0, "os_w1c");
    ir(0, "os_irq_clr");
    idle_c(48'h80);
    idle(2);
    rd(16, 0, "os_no_refire");
    // periodic on ch1
    idle_c(0);
    wr(4, 10);
    wr(5, 0);
    wr(6, 5);
    wr(7, 3);
    for (int k = 1; k <= 27; k++) idle_c(48'(k));
    idle(2);
    rd(7, 32'h0000_0307, "per_status");
    rd(4, 32'd30, "per_target");
    ir(0, "per_irq_masked");
    wr(17, 2);
    idle();
    ir(1, "per_irq");
    idle_c(48'h10000);
    idle(600);
    rd(7, 32'h0000_FF07, "per_sat");
    wr(7, 4);
    idle(3);
    wr(16, 2);
    rd(7, 32'h2, "per_clr");
    ir(0, "per_irq_clr");
    // wrap on ch2
    wr(17, 4);
    idle_c(48'hFFFF_FFFF_FFF0);
    wr(8, 8);
    wr(9, 0);
    wr(11, 1);
    idle(2);
    rd(16, 0, "wrap_nofire");
    idle_c(48'hFFFF_FFFF_FFFF);
    idle_c(0);
    idle_c(7);
    idle(2);
    rd(16, 0, "wrap_pre");
    idle_c(8);
    idle();
    rd(16, 4, "wrap_fire");
    ir(1, "wrap_irq");
    wr(16, 4);
    idle_c(48'h1000);
    wr(8, 32'hFF0);
    wr(11, 1);
    idle(2);
    rd(16, 4, "past_fire");
    // W1C racing a new hit on ch2
    wr(8, 32'h2000);
    wr(11, 1);
    idle_c(48'h2000);
    wr(16, 4);
    rd(16, 4, "race_pending");
    rd(11, 32'h4, "race_status");
    // periodic with period 0 on ch3
    wr(12, 32'h3000);
    wr(13, 0);
    wr(15, 3);
    idle_c(48'h3000);
    idle();
    rd(15, 32'h6, "p0_status");
    idle(4);
    rd(15, 32'h6, "p0_no_refire");
    // snapshot
    idle_c(48'h1234_5678_9ABC);
    rd(18, 32'h5678_9ABC, "cnt_lo");
    idle_c(48'h9999_0000_0000);
    rd(19, 32'h0000_1234, "snap_hi");
    rd(20, 0, "rsvd20");
    // reset mid-operation with ch0 armed
    wr(17, 32'hF);
    wr(0, 5);
    wr(1, 32'h9999);
    wr(3, 1);
    ir(1, "pre_rst_irq");
    ir(0, "rst_async_irq");
    rst = 1;
    idle();
    rst = 0;
    rd(3, 0, "rst2_ch0_status");
    rd(16, 0, "rst2_pending");
    rd(17, 0, "rst2_mask");
    rd(1, 0, "rst2_thi");
    idle_c(48'h9999_0000_0010);
    idle(3);
    rd(16, 0, "rst2_nofire");
    ir(0, "rst2_irq");
    idle(2);
    n_chk++;
    if (rq.size() + iq.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expect: got %0d, expected 0", rq.size() + iq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
